// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the instruction loader: FSM state encoding, stream
// framing constants and the default instruction-memory depth.
// Ports: none (package).
// -----------------------------------------------------------------------------
package instr_loader_pkg;

    localparam int DEFAULT_DEPTH = 256;
    localparam int LEN_BYTES     = 2;
    localparam int WORD_BYTES    = 4;
    localparam int WORD_W        = 8 * WORD_BYTES;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        WORD   = 3'd3,
        CHK    = 3'd4,
        FIN    = 3'd5,
        ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler
// Shifts incoming program bytes (least-significant first) into a 32-bit word
// and raises a one-cycle word_valid pulse in the cycle after the last byte of
// a word was taken.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   byte_valid in   a word byte is accepted this cycle
//   byte_data  in   the accepted byte
//   last_byte  in   the accepted byte is the 4th byte of its word
//   word_valid out  one-cycle pulse, word_data holds a complete word
//   word_data  out  assembled word {b3,b2,b1,b0}
// -----------------------------------------------------------------------------
module byte_assembler
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              last_byte,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data
);

    logic [WORD_W-1:0] shift_reg;

    // New bytes enter at the top so after four shifts the first byte sits in
    // bits [7:0]. A byte arriving during the word_valid cycle only changes
    // the register at the end of that cycle, so the presented word is intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && last_byte;
            if (byte_valid) begin
                shift_reg <= {byte_data, shift_reg[WORD_W-1:8]};
            end
        end
    end

    assign word_data = shift_reg;

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Receives a program over a byte stream (16-bit word count, low byte first,
// then N little-endian 32-bit words) and writes it into instruction memory,
// holding the CPU in reset until a load has completed.
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to expect one trailing
// checksum byte (XOR of all preceding stream bytes) checked in CHK.
// Parameters:
//   DEPTH      number of 32-bit words in the target memory
//   BASE_ADDR  byte address of the first word
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle load request (ignored while busy)
//   rx_valid  in   rx_data carries a byte
//   rx_data   in   incoming program byte
//   rx_ready  out  a byte is accepted this cycle when rx_valid is high
//   wr_en     out  instruction-memory write strobe
//   wr_addr   out  word-aligned write byte address
//   wr_data   out  instruction word to write
//   cpu_hold  out  keeps the processor in reset unless the load finished
//   busy      out  load in progress
//   done      out  last load completed
//   error     out  last load aborted
// -----------------------------------------------------------------------------
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // One extra bit so the index can reach DEPTH without wrapping.
    localparam int          IDX_W   = $clog2(DEPTH) + 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [31:0] BASE_AL = BASE_ADDR & 32'hFFFF_FFFC;

    state_t            state;
    state_t            state_next;
    logic [1:0]        byte_cnt;
    logic [IDX_W-1:0]  word_idx;
    logic [7:0]        len_lo;
    logic [15:0]       word_count;
    logic [31:0]       addr_reg;
    logic              accept;
    logic              start_load;
    logic              word_byte;
    logic              last_byte;
    logic              last_word;
    logic [15:0]       len_in;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign accept     = rx_valid && rx_ready;
    assign start_load = start && (state == IDLE || state == FIN || state == ERR);
    assign word_byte  = accept && (state == WORD);
    assign last_byte  = (byte_cnt == 2'd3);
    assign last_word  = (32'(word_idx) + 32'd1) == 32'(word_count);
    assign len_in     = {rx_data, len_lo};

    // Status outputs decode straight from the state register, so they take
    // their idle values the moment reset forces IDLE.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            LEN_LO, LEN_HI, WORD: rx_ready = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHK:                  rx_ready = 1'b1;
`endif
            default:              rx_ready = 1'b0;
        endcase
    end

    assign busy     = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == WORD)   || (state == CHK);
    assign done     = (state == FIN);
    assign error    = (state == ERR);
    assign cpu_hold = (state != FIN);
    assign wr_addr  = addr_reg;

    // Next-state logic. An oversized count aborts before any write; a zero
    // count skips straight to the check state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, FIN, ERR: begin
                if (start) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (32'(len_in) > DEPTH_U) state_next = ERR;
                    else if (len_in == 16'd0)  state_next = CHK;
                    else                       state_next = WORD;
                end
            end
            WORD: begin
                if (accept && last_byte && last_word) state_next = CHK;
            end
            CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                if (accept) state_next = (rx_data == csum) ? FIN : ERR;
`else
                state_next = FIN;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Counters, captured length and write address. The address is latched
    // together with the 4th byte so it lines up with the write pulse that
    // follows one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            word_idx   <= '0;
            len_lo     <= '0;
            word_count <= '0;
            addr_reg   <= '0;
        end else if (start_load) begin
            byte_cnt   <= '0;
            word_idx   <= '0;
            len_lo     <= '0;
            word_count <= '0;
        end else begin
            if (accept && state == LEN_LO) len_lo <= rx_data;
            if (accept && state == LEN_HI) word_count <= len_in;
            if (word_byte) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) begin
                    addr_reg <= BASE_AL + (32'(word_idx) << 2);
                    word_idx <= word_idx + 1'b1;
                end
            end
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Running XOR over the count bytes and all word bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (start_load) begin
            csum <= '0;
        end else if (accept && (state == LEN_LO || state == LEN_HI || state == WORD)) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    byte_assembler u_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (word_byte),
        .byte_data  (rx_data),
        .last_byte  (last_byte),
        .word_valid (wr_en),
        .word_data  (wr_data)
    );

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
// Directed self-checking bench for instr_loader (DEPTH=256, BASE_ADDR=0).
// Honours INSTR_LOADER_CHECKSUM_EN by appending the checksum byte.
// -----------------------------------------------------------------------------
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int          checkCount = 0;
    int          failCount  = 0;
    logic [7:0]  runXor;
    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];

    instr_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Record every write strobe away from the active edge.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            wrAddrQ.push_back(wr_addr);
            wrDataQ.push_back(wr_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Offer one byte, optionally after a few random idle cycles, and wait for
    // the handshake. Called and returning on a falling edge.
    task automatic applyStimulus(input logic [7:0] b, input int gapMax);
        int guard;
        bit taken;
        repeat ($urandom_range(0, gapMax)) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        guard    = 0;
        taken    = 1'b0;
        while (!taken && guard < 200) begin
            taken = rx_ready;
            @(negedge clk);
            guard++;
        end
        if (!taken) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
        else        runXor = runXor ^ b;
        rx_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        runXor = 8'h00;
    endtask

    task automatic sendTrailer();
`ifdef INSTR_LOADER_CHECKSUM_EN
        applyStimulus(runXor, 0);
`endif
    endtask

    task automatic sendWord(input logic [31:0] w, input int gapMax);
        applyStimulus(w[7:0], gapMax);
        applyStimulus(w[15:8], gapMax);
        applyStimulus(w[23:16], gapMax);
        applyStimulus(w[31:24], gapMax);
    endtask

    task automatic waitFinish(input string tag);
        int g = 0;
        while (!done && !error && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) checkOutput(tag, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic clearWrites();
        wrAddrQ.delete();
        wrDataQ.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        checkOutput({tag, "_wr_en"},    32'(wr_en),    32'd0);
        checkOutput({tag, "_wr_addr"},  wr_addr,       32'd0);
        checkOutput({tag, "_wr_data"},  wr_data,       32'd0);
        checkOutput({tag, "_busy"},     32'(busy),     32'd0);
        checkOutput({tag, "_done"},     32'(done),     32'd0);
        checkOutput({tag, "_error"},    32'(error),    32'd0);
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    function automatic logic [31:0] patWord(input int k);
        logic [7:0] kb;
        kb = k[7:0];
        return {kb ^ 8'h5A, kb + 8'h33, ~kb, kb};
    endfunction

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        runXor   = 8'h00;
        #1;
        checkIdleOutputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);

        // Scenario 1: two words, with a start pulse mid-load that must be ignored.
        clearWrites();
        pulseStart();
        checkOutput("s1_busy", 32'(busy), 32'd1);
        checkOutput("s1_rx_ready", 32'(rx_ready), 32'd1);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("s1_start_ignored_busy", 32'(busy), 32'd1);
        sendWord(32'h0050_0013, 0);
        sendWord(32'h0010_05B3, 0);
        sendTrailer();
        waitFinish("s1_finish_timeout");
        checkOutput("s1_writes", wrAddrQ.size(), 32'd2);
        if (wrAddrQ.size() == 2) begin
            checkOutput("s1_addr0", wrAddrQ[0], 32'h0000_0000);
            checkOutput("s1_data0", wrDataQ[0], 32'h0050_0013);
            checkOutput("s1_addr1", wrAddrQ[1], 32'h0000_0004);
            checkOutput("s1_data1", wrDataQ[1], 32'h0010_05B3);
        end
        checkOutput("s1_done",     32'(done),     32'd1);
        checkOutput("s1_error",    32'(error),    32'd0);
        checkOutput("s1_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("s1_busy_end", 32'(busy),     32'd0);

        // Scenario 2: empty program.
        clearWrites();
        pulseStart();
        checkOutput("s2_done_cleared", 32'(done), 32'd0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
`ifndef INSTR_LOADER_CHECKSUM_EN
        checkOutput("s2_done_chk_cycle", 32'(done), 32'd0);
        checkOutput("s2_busy_chk_cycle", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("s2_done_timing", 32'(done), 32'd1);
`else
        sendTrailer();
        waitFinish("s2_finish_timeout");
        checkOutput("s2_done", 32'(done), 32'd1);
`endif
        checkOutput("s2_writes", wrAddrQ.size(), 32'd0);

        // Scenario 3: count larger than DEPTH aborts.
        clearWrites();
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h01, 0);
        checkOutput("s3_error",    32'(error),    32'd1);
        checkOutput("s3_done",     32'(done),     32'd0);
        checkOutput("s3_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("s3_cpu_hold", 32'(cpu_hold), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("s3_error_sticky", 32'(error), 32'd1);
        checkOutput("s3_writes", wrAddrQ.size(), 32'd0);

        // Scenario 4: full-depth load with random valid gaps.
        clearWrites();
        pulseStart();
        checkOutput("s4_error_cleared", 32'(error), 32'd0);
        applyStimulus(8'h00, 2);
        applyStimulus(8'h01, 2);
        for (int k = 0; k < 256; k++) sendWord(patWord(k), 2);
        sendTrailer();
        waitFinish("s4_finish_timeout");
        checkOutput("s4_writes", wrAddrQ.size(), 32'd256);
        for (int k = 0; k < 256 && k < wrAddrQ.size(); k++) begin
            checkOutput($sformatf("s4_addr%0d", k), wrAddrQ[k], 32'(k) << 2);
            checkOutput($sformatf("s4_data%0d", k), wrDataQ[k], patWord(k));
        end
        checkOutput("s4_done", 32'(done), 32'd1);

        // Scenario 5: reset in the middle of a load, then a fresh one-word load.
        pulseStart();
        applyStimulus(8'h03, 0);
        applyStimulus(8'h00, 0);
        sendWord(32'h4433_2211, 0);
        #2;
        rst_n = 1'b0;
        #1;
        clearWrites();
        checkIdleOutputs("s5_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        sendWord(32'hDEAD_BEEF, 0);
        sendTrailer();
        waitFinish("s5_finish_timeout");
        checkOutput("s5_writes", wrAddrQ.size(), 32'd1);
        if (wrAddrQ.size() == 1) begin
            checkOutput("s5_addr0", wrAddrQ[0], 32'h0000_0000);
            checkOutput("s5_data0", wrDataQ[0], 32'hDEAD_BEEF);
        end
        checkOutput("s5_done", 32'(done), 32'd1);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Scenario 6: correct and wrong checksum bytes.
        clearWrites();
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        sendWord(32'h0000_0013, 0);
        applyStimulus(8'h12, 0);
        waitFinish("s6a_finish_timeout");
        checkOutput("s6a_done",  32'(done),  32'd1);
        checkOutput("s6a_error", 32'(error), 32'd0);
        clearWrites();
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        sendWord(32'h0000_0013, 0);
        applyStimulus(8'h13, 0);
        waitFinish("s6b_finish_timeout");
        checkOutput("s6b_error",    32'(error),    32'd1);
        checkOutput("s6b_done",     32'(done),     32'd0);
        checkOutput("s6b_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("s6b_writes", wrAddrQ.size(), 32'd1);
        if (wrDataQ.size() == 1) checkOutput("s6b_data0", wrDataQ[0], 32'h0000_0013);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
